xalu_cfg_seq: RTL and testbench

Configuration sequencer that drives the `configdata` port of an `xalu` instance. A host writes ALU function and operand-select fields into a shadow register and commits them into a small configuration queue. On `run`, the block pops queued configurations one at a time, holds each active on `configdata` for a programmed number of cycles, and signals completion. It sits between the Versat control bus and each ALU functional unit, on the producing end of the ALU configuration interface.

---
 rtl/xalu_cfg_seq.sv | 118 +++++++++++
 tb/tb_xalu_cfg_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/xalu_cfg_seq.sv
// ALU configuration sequencer: a shadow register feeds a small FIFO of configs, and
// each queued config is driven onto configdata for its programmed number of cycles.
module xalu_cfg_seq #(
  parameter int DEPTH         = 4,
  parameter int LEN_W         = 16,
  parameter int DATA_W        = 32,
  parameter int N_W           = 5,
  parameter int ALU_FNS_W     = 4,
  parameter int ALU_CONF_BITS = 2*N_W + ALU_FNS_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  input  logic [1:0]                cfg_addr,
  input  logic [DATA_W-1:0]         cfg_data,
  input  logic                      commit,
  input  logic                      run,
  output logic [ALU_CONF_BITS-1:0]  configdata,
  output logic                      busy,
  output logic                      done,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      err
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [ALU_FNS_W-1:0] fns;
    logic [N_W-1:0]       sela;
    logic [N_W-1:0]       selb;
    logic [LEN_W-1:0]     len;
  } cfg_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  cfg_t             shadow;
  cfg_t             q_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LEN_W-1:0] cnt;
  logic             armed;

  cfg_t             head;
  logic [LEN_W-1:0] head_len;
  logic             last, pop, push;

  function automatic logic [ALU_CONF_BITS-1:0] conf_of(input cfg_t c);
    conf_of = '0;
    conf_of[ALU_CONF_BITS-1 -: N_W]       = c.sela;
    conf_of[ALU_CONF_BITS-N_W-1 -: N_W]   = c.selb;
    conf_of[ALU_FNS_W-1:0]                = c.fns;
  endfunction

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign head     = q_mem[rd_ptr];
  assign head_len = (head.len == '0) ? LEN_W'(1) : head.len;
  assign last     = (state == RUN) && (cnt == LEN_W'(1));
  // A pop on the last cycle of an entry makes the next one active with no bubble.
  assign pop      = !empty && (((state == IDLE) && (armed || run)) || last);
  assign push     = commit && (!full || pop);

  // Queue storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= shadow;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shadow     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      cnt        <= '0;
      armed      <= 1'b0;
      configdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (cfg_valid) begin
        case (cfg_addr)
          2'd0:    shadow.fns  <= cfg_data[ALU_FNS_W-1:0];
          2'd1:    shadow.sela <= cfg_data[N_W-1:0];
          2'd2:    shadow.selb <= cfg_data[N_W-1:0];
          default: shadow.len  <= cfg_data[LEN_W-1:0];
        endcase
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (commit && full && !pop) err <= 1'b1;

      if ((state == IDLE) && run) armed <= 1'b1;

      if (pop) begin
        state      <= RUN;
        configdata <= conf_of(head);
        busy       <= 1'b1;
        cnt        <= head_len;
        done       <= (head_len == LEN_W'(1));
      end else if (state == RUN) begin
        if (last) begin
          state <= IDLE;
          busy  <= 1'b0;
          armed <= 1'b0;
          done  <= 1'b0;
        end else begin
          cnt  <= cnt - LEN_W'(1);
          done <= (cnt == LEN_W'(2));
        end
      end
    end
  end
endmodule

// File: tb/tb_xalu_cfg_seq.sv
// Bench for xalu_cfg_seq: directed vector table, hand sequences for queue corners,
// then random traffic, all cross-checked against a queue-based reference model.
module tb_xalu_cfg_seq;
  localparam int DEPTH = 4;
  localparam int CB    = 14;
  localparam logic [3:0] ALU_ADD = 4'd6;

  logic          clk = 1'b0, rst = 1'b0, cfg_valid = 1'b0, commit = 1'b0, run = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [31:0]   cfg_data = '0;
  logic [CB-1:0] configdata;
  logic          busy, done, empty, full, err;
  logic [2:0]    level;

  int n_chk = 0, n_err = 0;

  xalu_cfg_seq #(.DEPTH(DEPTH), .LEN_W(16), .DATA_W(32), .N_W(5), .ALU_FNS_W(4),
                 .ALU_CONF_BITS(CB)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .commit(commit), .run(run), .configdata(configdata), .busy(busy), .done(done),
    .empty(empty), .full(full), .level(level), .err(err));

  always #5 clk = ~clk;

  // Reference model: a queue of entries plus the currently active entry.
  typedef struct { int fns; int sela; int selb; int len; } ent_t;
  ent_t mq[$];
  ent_t msh, mcur;
  bit   mact, marmed, merr;
  int   mrem;

  function automatic logic [CB-1:0] conf(input int sa, input int sb, input int fn);
    return {5'(sa), 5'(sb), 4'(fn)};
  endfunction

  task automatic model_step(input logic r, input logic cv, input logic [1:0] a,
                            input logic [31:0] d, input logic cm, input logic rn);
    ent_t old, h;
    bit   was_act, dopop;
    if (!r) begin
      mq.delete();
      msh = '{0, 0, 0, 0};
      mcur = '{0, 0, 0, 0};
      mact = 0; marmed = 0; merr = 0; mrem = 0;
      return;
    end
    old = msh;
    was_act = mact;
    dopop = (mq.size() > 0) && ((!mact && (marmed || rn)) || (mact && mrem == 1));
    if (dopop) h = mq.pop_front();
    if (cm) begin
      if (mq.size() < DEPTH) mq.push_back(old);
      else merr = 1;
    end
    if (cv) begin
      case (a)
        2'd0: msh.fns  = int'(d[3:0]);
        2'd1: msh.sela = int'(d[4:0]);
        2'd2: msh.selb = int'(d[4:0]);
        default: msh.len = int'(d[15:0]);
      endcase
    end
    if (!was_act && rn) marmed = 1;
    if (dopop) begin
      mact = 1; mcur = h; mrem = (h.len == 0) ? 1 : h.len;
    end else if (was_act) begin
      if (mrem == 1) begin mact = 0; marmed = 0; end
      else mrem--;
    end
  endtask

  task automatic check_out(input string name, input logic eb, input logic ed,
                           input logic [2:0] el, input logic [CB-1:0] ec, input logic eerr);
    logic ee, ef;
    ee = (el == 0);
    ef = (el == DEPTH);
    n_chk++;
    if ({busy, done, level, configdata, err, empty, full} !== {eb, ed, el, ec, eerr, ee, ef}) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b level=%0d conf=%h err=%b empty=%b full=%b; want busy=%b done=%b level=%0d conf=%h err=%b empty=%b full=%b",
               name, busy, done, level, configdata, err, empty, full, eb, ed, el, ec, eerr, ee, ef);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it.
  task automatic step(input logic r, input logic cv, input logic [1:0] a,
                      input logic [31:0] d, input logic cm, input logic rn);
    rst = r; cfg_valid = cv; cfg_addr = a; cfg_data = d; commit = cm; run = rn;
    @(posedge clk);
    model_step(r, cv, a, d, cm, rn);
    #1;
    check_out("model", mact, mact && (mrem == 1), 3'(mq.size()),
              conf(mcur.sela, mcur.selb, mcur.fns), merr);
  endtask

  task automatic idle();                             step(1, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [1:0] a, input int d); step(1, 1, a, d, 0, 0); endtask
  task automatic cmt();                              step(1, 0, 0, 0, 1, 0); endtask
  task automatic go();                               step(1, 0, 0, 0, 0, 1); endtask
  task automatic rstc();
    step(0, 1'($urandom), 2'($urandom), $urandom, 1'($urandom), 1'($urandom));
  endtask

  typedef struct {
    logic r, cv; logic [1:0] a; logic [31:0] d; logic cm, rn;
    logic eb, ed; logic [2:0] el; logic [CB-1:0] ec; logic eerr;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic r, input logic cv, input logic [1:0] a, input logic [31:0] d,
                      input logic cm, input logic rn, input logic eb, input logic ed,
                      input logic [2:0] el, input logic [CB-1:0] ec, input logic eerr);
    vec_t v;
    v = '{r, cv, a, d, cm, rn, eb, ed, el, ec, eerr};
    tbl.push_back(v);
  endtask

  initial begin
    logic [CB-1:0] x;
    x = conf(0, 1, ALU_ADD);
    // Reset, then single entry {sela=0, selb=1, ADD}, len 3, run at row 7.
    addv(0, 0, 0, 0, 0, 0,  0, 0, 0, '0, 0);
    addv(0, 0, 0, 0, 0, 0,  0, 0, 0, '0, 0);
    addv(1, 1, 0, 32'(ALU_ADD), 0, 0, 0, 0, 0, '0, 0);
    addv(1, 1, 1, 0, 0, 0,  0, 0, 0, '0, 0);
    addv(1, 1, 2, 1, 0, 0,  0, 0, 0, '0, 0);
    addv(1, 1, 3, 3, 0, 0,  0, 0, 0, '0, 0);
    addv(1, 0, 0, 0, 1, 0,  0, 0, 1, '0, 0);
    addv(1, 0, 0, 0, 0, 1,  1, 0, 0, x, 0);
    addv(1, 0, 0, 0, 0, 0,  1, 0, 0, x, 0);
    addv(1, 0, 0, 0, 0, 0,  1, 1, 0, x, 0);
    addv(1, 0, 0, 0, 0, 0,  0, 0, 0, x, 0);
    addv(1, 0, 0, 0, 0, 0,  0, 0, 0, x, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].r) rstc();
      else step(tbl[i].r, tbl[i].cv, tbl[i].a, tbl[i].d, tbl[i].cm, tbl[i].rn);
      check_out($sformatf("vec%0d", i), tbl[i].eb, tbl[i].ed, tbl[i].el, tbl[i].ec, tbl[i].eerr);
    end

    // Back-to-back windows of 2, 1, 1 cycles.
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 2); cmt();
    wr(0, 2); wr(1, 4); wr(2, 5); wr(3, 1); cmt();
    wr(0, 3); wr(1, 6); wr(2, 7); wr(3, 0); cmt();
    check_out("b2b_queued", 0, 0, 3, x, 0);
    go();   check_out("b2b_a1", 1, 0, 2, conf(2, 3, 1), 0);
    idle(); check_out("b2b_a2", 1, 1, 2, conf(2, 3, 1), 0);
    idle(); check_out("b2b_b",  1, 1, 1, conf(4, 5, 2), 0);
    idle(); check_out("b2b_c",  1, 1, 0, conf(6, 7, 3), 0);
    idle(); check_out("b2b_end", 0, 0, 0, conf(6, 7, 3), 0);

    // Overflow: fifth commit dropped, marker fns 12 never issued.
    wr(3, 1);
    for (int k = 0; k < 5; k++) begin wr(0, 8 + k); cmt(); end
    check_out("ovf_full", 0, 0, 4, conf(6, 7, 3), 1);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) go(); else idle();
      check_out($sformatf("ovf_issue%0d", k), 1, 1, 3'(3 - k), conf(6, 7, 8 + k), 1);
    end
    idle(); check_out("ovf_drained", 0, 0, 0, conf(6, 7, 11), 1);

    // Commit while full in the same cycle as a pop is accepted.
    rstc(); rstc(); check_out("rst2", 0, 0, 0, '0, 0);
    wr(3, 2);
    for (int k = 0; k < 4; k++) cmt();
    check_out("fp_full", 0, 0, 4, '0, 0);
    step(1, 0, 0, 0, 1, 1); check_out("fp_pop", 1, 0, 4, '0, 0);
    for (int k = 0; k < 12; k++) idle();
    check_out("fp_drained", 0, 0, 0, '0, 0);

    // Armed start with empty queue.
    rstc();
    go(); check_out("arm_run", 0, 0, 0, '0, 0);
    wr(3, 2); wr(0, 5); idle(); idle(); idle();
    cmt();  check_out("arm_c1", 0, 0, 1, '0, 0);
    idle(); check_out("arm_c2", 1, 0, 0, conf(0, 0, 5), 0);
    idle(); check_out("arm_c3", 1, 1, 0, conf(0, 0, 5), 0);
    idle(); check_out("arm_c4", 0, 0, 0, conf(0, 0, 5), 0);

    // Reset during the first entry flushes the queue and disarms.
    wr(3, 3); cmt(); cmt(); cmt();
    go(); check_out("mr_run", 1, 0, 2, conf(0, 0, 5), 0);
    rstc(); check_out("mr_rst", 0, 0, 0, '0, 0);
    go(); idle(); idle(); idle();
    check_out("mr_norun", 0, 0, 0, '0, 0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] a;
      logic [31:0] d;
      a = 2'($urandom);
      d = (a == 2'd3) ? 32'($urandom_range(0, 4)) : $urandom;
      if ($urandom_range(0, 199) == 0) rstc();
      else step(1, 1'($urandom_range(0, 2) == 0), a, d,
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
